game_level_controller: RTL and testbench
========================================

Name: game_level_controller

Overview:
Game-flow state machine that produces the 2-bit levelCode consumed by the per-level bitmap selector mux. It tracks lives and level progression from per-frame game events, and freezes gameplay for a fixed number of frames after each level start or death. It also holds the WIN and GAME_OVER screens for a minimum time before a restart is accepted. It sits between the collision/game-logic blocks and the video/bitmap path.

Parameters:
LIVES_INIT, 3, lives loaded at reset and restart; legal range 1..7.
FREEZE_FRAMES, 60, frames of freeze after entering a level or after a non-fatal hit; legal range 1..255.
END_FRAMES, 180, minimum frames the WIN or GAME_OVER screen is shown before restart is accepted; legal range 1..255.

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
startOfFrame  input  1  one-cycle pulse, once per video frame
levelDone  input  1  one-cycle pulse: the player cleared the current level
playerHit  input  1  one-cycle pulse: the player lost a life
restartKey  input  1  level-sensitive key (already synchronised); rising edge requests a restart
levelCode  output  2  00 LEVEL_ONE, 01 LEVEL_TWO, 10 WIN, 11 GAME_OVER
lives  output  3  remaining lives
freeze  output  1  1 = game objects must hold position
levelStart  output  1  one-cycle pulse: objects reload start positions, play begins

Behaviour:
- Reset is asynchronous and active-low. During reset the outputs are:
  - levelCode=00, lives=LIVES_INIT, freeze=1, levelStart=0.
  - Freeze counter = FREEZE_FRAMES, end counter = 0, restartKey edge register = 0.
  - Reset asserted mid-operation aborts everything immediately to these values.
- States: S_L1 (code 00), S_L2 (01), S_WIN (10), S_OVER (11). levelCode is a registered output and always equals the state encoding.
- Freeze counter, 8 bits:
  - In S_L1/S_L2 with counter > 0: decrements on each startOfFrame. freeze = 1 while counter != 0.
  - On the cycle the counter goes 1→0, levelStart pulses for exactly 1 cycle, and freeze drops to 0 in that same cycle (registered with the counter).
  - The latency from the last required startOfFrame to levelStart=1 is 1 clk.
- Event handling, only in S_L1/S_L2 with freeze=0. Events arriving while freeze=1 are dropped, not queued.
  - levelDone in S_L1: go to S_L2, reload freeze counter = FREEZE_FRAMES, freeze=1.
  - levelDone in S_L2: go to S_WIN, end counter = END_FRAMES, freeze=1.
  - playerHit with lives > 1: lives -= 1, stay in the current level, reload freeze counter, freeze=1. The player restarts the same level.
  - playerHit with lives == 1: lives = 0, go to S_OVER, end counter = END_FRAMES, freeze=1.
  - levelDone and playerHit in the same cycle: levelDone wins, lives unchanged.
  - An event coinciding with startOfFrame: the event is processed. The new freeze counter is loaded with FREEZE_FRAMES, not decremented, that cycle.
- S_WIN / S_OVER:
  - freeze=1 at all times.
  - End counter decrements on startOfFrame until 0, then saturates at 0.
  - levelDone and playerHit are ignored.
- Restart:
  - A rising edge of restartKey is detected against a 1-cycle-delayed register.
  - It is acted on only in S_WIN/S_OVER with end counter == 0. The resulting load is: S_L1, lives=LIVES_INIT, freeze counter = FREEZE_FRAMES.
  - Edges arriving earlier are discarded. A key held from before expiry does not restart; a new edge is required.
  - restartKey is ignored in S_L1/S_L2.
- lives never underflows below 0 and never exceeds LIVES_INIT.
- After reset, the first levelStart occurs after FREEZE_FRAMES startOfFrame pulses.
- No combinational path exists from inputs to outputs.

Test Plan:
All scenarios use LIVES_INIT=3, FREEZE_FRAMES=2, END_FRAMES=3.
- Reset release, 2 startOfFrame pulses → freeze 1→0 and levelStart one 1-cycle pulse one clk after the 2nd pulse; levelCode=00, lives=3.
- After unfreeze, levelDone → levelCode=01, freeze=1; 2 frames later levelStart pulses. A second levelDone → levelCode=10.
- In S_L1 unfrozen, 3 playerHit pulses, each followed by 2 frames → lives 2, 1, then 0 with levelCode=11 on the 3rd hit.
- playerHit during freeze → lives unchanged. levelDone+playerHit in the same cycle while unfrozen → level advances, lives unchanged.
- In S_OVER, restartKey rising after 1 frame → ignored; key held through 3 frames → still S_OVER. Release then press → levelCode=00, lives=3, freeze=1.
- resetN asserted mid-S_L2 with lives=1 → immediately levelCode=00, lives=3, freeze=1, levelStart=0.

Source files
------------

// File: rtl/game_level_controller.sv
// rtl/game_level_controller.sv - game-flow FSM producing levelCode, lives, freeze and levelStart
//
// Purpose: tracks level progression and lives from per-frame game events, holds
// gameplay frozen for FREEZE_FRAMES frames after each level (re)start, and holds
// the WIN / GAME_OVER screens for at least END_FRAMES frames before a restart.
//
// Ports:
//   clk          system clock
//   resetN       asynchronous active-low reset
//   startOfFrame one-cycle pulse per video frame
//   levelDone    one-cycle pulse, current level cleared
//   playerHit    one-cycle pulse, player lost a life
//   restartKey   synchronised level key, rising edge requests restart
//   levelCode    00 LEVEL_ONE, 01 LEVEL_TWO, 10 WIN, 11 GAME_OVER (registered)
//   lives        remaining lives (registered)
//   freeze       1 while game objects must hold position
//   levelStart   one-cycle pulse when play begins (registered)
module game_level_controller #(
    parameter int LIVES_INIT    = 3,
    parameter int FREEZE_FRAMES = 60,
    parameter int END_FRAMES    = 180
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       levelDone,
    input  logic       playerHit,
    input  logic       restartKey,
    output logic [1:0] levelCode,
    output logic [2:0] lives,
    output logic       freeze,
    output logic       levelStart
);

    typedef enum logic [1:0] {
        S_L1   = 2'b00,
        S_L2   = 2'b01,
        S_WIN  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam logic [2:0] C_LIVES_INIT = 3'(LIVES_INIT);
    localparam logic [7:0] C_FREEZE     = 8'(FREEZE_FRAMES);
    localparam logic [7:0] C_END        = 8'(END_FRAMES);

    state_t     r_state,       w_state_nxt;
    logic [2:0] r_lives,       w_lives_nxt;
    logic [7:0] r_freeze_cnt,  w_freeze_cnt_nxt;
    logic [7:0] r_end_cnt,     w_end_cnt_nxt;
    logic       r_level_start, w_level_start_nxt;
    logic       r_key_d;
    logic       w_key_rise;
    logic       w_in_level;

    assign w_key_rise = restartKey & ~r_key_d;
    assign w_in_level = (r_state == S_L1) || (r_state == S_L2);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_L1;
            r_lives       <= C_LIVES_INIT;
            r_freeze_cnt  <= C_FREEZE;
            r_end_cnt     <= 8'd0;
            r_level_start <= 1'b0;
            r_key_d       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lives       <= w_lives_nxt;
            r_freeze_cnt  <= w_freeze_cnt_nxt;
            r_end_cnt     <= w_end_cnt_nxt;
            r_level_start <= w_level_start_nxt;
            r_key_d       <= restartKey;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_lives_nxt       = r_lives;
        w_freeze_cnt_nxt  = r_freeze_cnt;
        w_end_cnt_nxt     = r_end_cnt;
        w_level_start_nxt = 1'b0;

        if (w_in_level) begin
            if (r_freeze_cnt != 8'd0) begin
                // Frozen: count frames down; events are dropped, not queued.
                if (startOfFrame) begin
                    w_freeze_cnt_nxt = r_freeze_cnt - 8'd1;
                    if (r_freeze_cnt == 8'd1) begin
                        w_level_start_nxt = 1'b1;
                    end
                end
            end else if (levelDone) begin
                // levelDone has priority over a simultaneous playerHit.
                if (r_state == S_L1) begin
                    w_state_nxt      = S_L2;
                    w_freeze_cnt_nxt = C_FREEZE;
                end else begin
                    w_state_nxt   = S_WIN;
                    w_end_cnt_nxt = C_END;
                end
            end else if (playerHit) begin
                if (r_lives > 3'd1) begin
                    w_lives_nxt      = r_lives - 3'd1;
                    w_freeze_cnt_nxt = C_FREEZE;
                end else begin
                    w_lives_nxt   = 3'd0;
                    w_state_nxt   = S_OVER;
                    w_end_cnt_nxt = C_END;
                end
            end
        end else begin
            if (startOfFrame && (r_end_cnt != 8'd0)) begin
                w_end_cnt_nxt = r_end_cnt - 8'd1;
            end
            // Only a fresh edge after the hold time expires restarts the game.
            if ((r_end_cnt == 8'd0) && w_key_rise) begin
                w_state_nxt      = S_L1;
                w_lives_nxt      = C_LIVES_INIT;
                w_freeze_cnt_nxt = C_FREEZE;
            end
        end
    end

    assign levelCode  = r_state;
    assign lives      = r_lives;
    // End screens are always frozen; in a level freeze tracks the counter.
    assign freeze     = !w_in_level || (r_freeze_cnt != 8'd0);
    assign levelStart = r_level_start;

endmodule

// File: tb/tb_game_level_controller.sv
// tb/tb_game_level_controller.sv - directed self-checking bench for game_level_controller
module tb_game_level_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       levelDone;
    logic       playerHit;
    logic       restartKey;
    logic [1:0] levelCode;
    logic [2:0] lives;
    logic       freeze;
    logic       levelStart;

    int total = 0;
    int bad   = 0;

    game_level_controller #(
        .LIVES_INIT   (3),
        .FREEZE_FRAMES(2),
        .END_FRAMES   (3)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .levelDone   (levelDone),
        .playerHit   (playerHit),
        .restartKey  (restartKey),
        .levelCode   (levelCode),
        .lives       (lives),
        .freeze      (freeze),
        .levelStart  (levelStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive pulses for one clock edge, return at the next negedge.
    task automatic step(input logic sof, input logic ld, input logic ph);
        startOfFrame = sof;
        levelDone    = ld;
        playerHit    = ph;
        @(negedge clk);
        startOfFrame = 1'b0;
        levelDone    = 1'b0;
        playerHit    = 1'b0;
    endtask

    task automatic frame();
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] code, input logic [2:0] lv,
                           input logic frz, input logic ls);
        chk({tag, "_code"},  8'(levelCode),  8'(code));
        chk({tag, "_lives"}, 8'(lives),      8'(lv));
        chk({tag, "_frz"},   8'(freeze),     8'(frz));
        chk({tag, "_ls"},    8'(levelStart), 8'(ls));
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        levelDone    = 1'b0;
        playerHit    = 1'b0;
        restartKey   = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 2'b00, 3'd3, 1'b1, 1'b0);
        resetN = 1'b1;
        tick();
        chk_all("post_reset", 2'b00, 3'd3, 1'b1, 1'b0);

        // First unfreeze after two frames, levelStart one clk after 2nd frame.
        frame();
        chk_all("frame1", 2'b00, 3'd3, 1'b1, 1'b0);
        frame();
        chk_all("frame2", 2'b00, 3'd3, 1'b0, 1'b1);
        tick();
        chk_all("ls_drop", 2'b00, 3'd3, 1'b0, 1'b0);

        // Level progression to WIN.
        step(1'b0, 1'b1, 1'b0);
        chk_all("l2_enter", 2'b01, 3'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_all("l2_done_dropped", 2'b01, 3'd3, 1'b1, 1'b0);
        frame();
        frame();
        chk_all("l2_start", 2'b01, 3'd3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk_all("win", 2'b10, 3'd3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_all("win_hit_ign", 2'b10, 3'd3, 1'b1, 1'b0);
        frame();
        frame();
        frame();
        restartKey = 1'b1;
        tick();
        chk_all("win_restart", 2'b00, 3'd3, 1'b1, 1'b0);
        restartKey = 1'b0;

        // Hits in level one down to game over.
        frame();
        frame();
        chk_all("l1_again", 2'b00, 3'd3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_all("hit1", 2'b00, 3'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_all("hit_frozen", 2'b00, 3'd2, 1'b1, 1'b0);
        frame();
        frame();
        chk_all("hit1_unfrz", 2'b00, 3'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_all("hit2", 2'b00, 3'd1, 1'b1, 1'b0);
        frame();
        frame();
        step(1'b0, 1'b0, 1'b1);
        chk_all("hit3_over", 2'b11, 3'd0, 1'b1, 1'b0);

        // Restart held off until end counter expires, and needs a fresh edge.
        frame();
        restartKey = 1'b1;
        tick();
        chk_all("early_key", 2'b11, 3'd0, 1'b1, 1'b0);
        frame();
        frame();
        tick();
        chk_all("held_key", 2'b11, 3'd0, 1'b1, 1'b0);
        restartKey = 1'b0;
        tick();
        chk_all("key_release", 2'b11, 3'd0, 1'b1, 1'b0);
        restartKey = 1'b1;
        tick();
        chk_all("over_restart", 2'b00, 3'd3, 1'b1, 1'b0);
        restartKey = 1'b0;

        // Simultaneous levelDone+playerHit: level wins, lives unchanged.
        frame();
        frame();
        step(1'b0, 1'b1, 1'b1);
        chk_all("both_events", 2'b01, 3'd3, 1'b1, 1'b0);
        frame();
        frame();
        step(1'b0, 1'b0, 1'b1);
        chk_all("l2_hit1", 2'b01, 3'd2, 1'b1, 1'b0);
        frame();
        frame();
        // Event coinciding with startOfFrame reloads rather than decrements.
        step(1'b1, 1'b0, 1'b1);
        chk_all("l2_hit_sof", 2'b01, 3'd1, 1'b1, 1'b0);
        frame();
        chk_all("reload_chk", 2'b01, 3'd1, 1'b1, 1'b0);
        frame();
        chk_all("l2_last_life", 2'b01, 3'd1, 1'b0, 1'b1);

        // Asynchronous reset mid-L2: takes effect without a clock edge.
        #2;
        resetN = 1'b0;
        #1;
        chk_all("async_reset", 2'b00, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        tick();
        chk_all("reset_hold", 2'b00, 3'd3, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
